// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath enables and mux selects as a Moore function of the state register.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic [3:0] state,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  state_e state_q, state_d;

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:   state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (op == OpStore) ? StMemWrite : StMemRead;
      StMemRead: state_d = StMemWb;
      StExecR:   state_d = StAluWb;
      StExecI:   state_d = StAluWb;
      StJal:     state_d = StAluWb;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Reset shows Fetch selects with every write/load strobe suppressed.
  always_comb begin
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ResultSrc = 2'b00;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    if (reset) begin
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
    end else begin
      case (state_q)
        StFetch: begin
          IRWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          PCUpdate  = 1'b1;
        end
        StDecode: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        StMemAdr: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        StMemRead: AdrSrc = 1'b1;
        StMemWb: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        StMemWrite: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        StExecR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        StExecI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        StAluWb: RegWrite = 1'b1;
        StBeq: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          Branch  = 1'b1;
        end
        StJal: begin
          ALUSrcA  = 2'b01;
          ALUSrcB  = 2'b10;
          PCUpdate = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: per-instruction state walks with a per-state output table.
module tb_main_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [3:0] state;
  logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;

  int n_total = 0;
  int n_bad   = 0;

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .state     (state),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, PCUpdate, Branch, RegWrite, MemWrite}
  localparam logic [13:0] CtrlResetGated = 14'b0_0_00_10_00_10_0_0_0_0;

  function automatic logic [13:0] ctrl_now();
    return {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
            PCUpdate, Branch, RegWrite, MemWrite};
  endfunction

  function automatic logic [13:0] exp_ctrl(input logic [3:0] s);
    case (s)
      4'd0:    return 14'b0_1_00_10_00_10_1_0_0_0;
      4'd1:    return 14'b0_0_01_01_00_00_0_0_0_0;
      4'd2:    return 14'b0_0_10_01_00_00_0_0_0_0;
      4'd3:    return 14'b1_0_00_00_00_00_0_0_0_0;
      4'd4:    return 14'b0_0_00_00_00_01_0_0_1_0;
      4'd5:    return 14'b1_0_00_00_00_00_0_0_0_1;
      4'd6:    return 14'b0_0_10_00_10_00_0_0_0_0;
      4'd7:    return 14'b0_0_10_01_10_00_0_0_0_0;
      4'd8:    return 14'b0_0_00_00_00_00_0_0_1_0;
      4'd9:    return 14'b0_0_10_00_01_00_0_1_0_0;
      4'd10:   return 14'b0_0_01_10_00_00_1_0_0_0;
      default: return 14'b0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // seq holds expected states, first in the low nibble; ends back in Fetch.
  task automatic run_instr(input string name, input logic [6:0] o, input int n,
                           input logic [23:0] seq);
    logic [3:0] s;
    op = o;
    for (int i = 0; i < n; i++) begin
      s = seq[i*4 +: 4];
      check_eq($sformatf("%s state[%0d]", name, i), 32'(state), 32'(s));
      check_eq($sformatf("%s ctrl[%0d]", name, i), 32'(ctrl_now()), 32'(exp_ctrl(s)));
      step();
    end
    check_eq($sformatf("%s end", name), 32'(state), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    op    = 7'b0110011;
    step();
    step();
    check_eq("rst state", 32'(state), 32'd0);
    check_eq("rst ctrl", 32'(ctrl_now()), 32'(CtrlResetGated));
    #2;
    check_eq("rst state late", 32'(state), 32'd0);
    check_eq("rst strobes late", 32'({IRWrite, PCUpdate, RegWrite, MemWrite, Branch}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post-rst IRWrite", 32'(IRWrite), 32'd1);
    check_eq("post-rst PCUpdate", 32'(PCUpdate), 32'd1);
    step();
    check_eq("R decode", 32'(state), 32'd1);
    step();
    check_eq("R exec", 32'(state), 32'd6);
    check_eq("R ALUOp", 32'(ALUOp), 32'b10);
    step();
    check_eq("R wb", 32'(state), 32'd8);
    step();
    check_eq("R end", 32'(state), 32'd0);

    run_instr("lw",   7'b0000011, 5, 24'h043210);
    run_instr("sw",   7'b0100011, 4, 24'h005210);
    run_instr("beq",  7'b1100011, 3, 24'h000910);
    run_instr("jal",  7'b1101111, 4, 24'h008A10);
    run_instr("itype", 7'b0010011, 4, 24'h008710);
    run_instr("rtype", 7'b0110011, 4, 24'h008610);
    run_instr("unsup", 7'b0110111, 2, 24'h000010);

    // lw interrupted by reset in MemRead
    op = 7'b0000011;
    step();
    step();
    step();
    check_eq("midrst memread", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    check_eq("midrst ctrl gated", 32'(ctrl_now()), 32'(CtrlResetGated));
    check_eq("midrst RegWrite", 32'(RegWrite), 32'd0);
    step();
    check_eq("midrst next", 32'(state), 32'd0);
    check_eq("midrst RegWrite2", 32'(RegWrite), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("midrst fetch IRWrite", 32'(IRWrite), 32'd1);
    run_instr("lw2", 7'b0000011, 5, 24'h043210);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback cycles and drives the datapath enables and mux selects. It produces `ALUOp[1:0]`, which feeds the ALU decoder directly; the ALU decoder combines it with `funct3`/`funct7b5`/`opb5` to form `ALUControl`. The design is Moore: all outputs are functions of the state register only.

## Interface
- No parameters.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: synchronous, active-high.
- `op` input 7: opcode field from the instruction register (`instr[6:0]`), valid from the Decode state onward.
- `state` output 4: current state encoding, for debug and verification.
- `AdrSrc` output 1: memory address select (0 = PC, 1 = ALU result register).
- `IRWrite` output 1: instruction register load strobe.
- `ALUSrcA` output 2: ALU A select (00 = PC, 01 = OldPC, 10 = rs1 data).
- `ALUSrcB` output 2: ALU B select (00 = rs2 data, 01 = ImmExt, 10 = constant 4).
- `ALUOp` output 2: to ALU decoder (00 = add, 01 = subtract/compare, 10 = decode funct fields).
- `ResultSrc` output 2: result mux (00 = ALUOut, 01 = Data, 10 = ALU result).
- `PCUpdate` output 1: unconditional PC load.
- `Branch` output 1: conditional PC load, qualified by Zero outside this block.
- `RegWrite` output 1: register file write strobe.
- `MemWrite` output 1: data memory write strobe.

## Operation
- State encoding: Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5, ExecuteR=6, ExecuteI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are illegal.
- Transitions (one per clock):
  - Fetch→Decode.
  - Decode→MemAdr when `op` is 0000011 (lw) or 0100011 (sw).
  - Decode→ExecuteR when `op` is 0110011.
  - Decode→ExecuteI when `op` is 0010011.
  - Decode→BEQ when `op` is 1100011.
  - Decode→JAL when `op` is 1101111.
  - Decode→Fetch for any other `op`. The instruction executes as a NOP; the PC was already advanced in Fetch.
  - MemAdr→MemRead for lw, MemAdr→MemWrite for sw. `op` is resampled here.
  - MemRead→MemWB. MemWB→Fetch. MemWrite→Fetch.
  - ExecuteR→ALUWB. ExecuteI→ALUWB. ALUWB→Fetch.
  - BEQ→Fetch. JAL→ALUWB.
  - Illegal state→Fetch.
- Outputs per state. Any field not listed is 0.
  - Fetch: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
  - Decode: ALUSrcA=01, ALUSrcB=01 (branch target precompute).
  - MemAdr: ALUSrcA=10, ALUSrcB=01.
  - MemRead: AdrSrc=1.
  - MemWB: ResultSrc=01, RegWrite=1.
  - MemWrite: AdrSrc=1, MemWrite=1.
  - ExecuteR: ALUSrcA=10, ALUOp=10.
  - ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - Illegal states: all outputs 0.
- Don't-care fields are driven as 0, so output values are deterministic.

## Timing
- The state register updates on the rising edge of `clk`. Outputs are combinational from the state register and carry no same-cycle dependency on `op`.
- Reset: on the first rising edge with `reset`=1, state becomes Fetch (0).
- Reset strobe gating: while `reset` is high, IRWrite, PCUpdate, RegWrite, MemWrite and Branch are forced to 0. The remaining outputs show Fetch values: ALUSrcB=10, ResultSrc=10, others 0.
- After reset deasserts, the first Fetch strobes are active in that same cycle.
- Reset asserted mid-instruction aborts it: the next state is Fetch. The strobes are gated in the reset cycle, so no partial RegWrite or MemWrite occurs.
- Cycles per instruction:
  - lw 5 (Fetch, Decode, MemAdr, MemRead, MemWB).
  - sw 4. R-type 4. I-type ALU 4. jal 4 (Fetch, Decode, JAL, ALUWB).
  - beq 3. Unsupported opcode 2.
- No handshakes; memory is assumed single-cycle.

## Test plan
- Reset check:
  - Stimulus: hold `reset`=1 for 2 cycles with `op`=0110011.
  - Required: `state`=0 and all strobes 0 during reset.
  - Then release reset. Required: state sequence 0,1,6,8,0 and ALUOp=10 in state 6.
- lw:
  - Stimulus: `op`=0000011.
  - Required: states 0,1,2,3,4,0.
  - MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. MemRead: AdrSrc=1. MemWB: ResultSrc=01, RegWrite=1.
- sw and beq:
  - sw (`op`=0100011). Required: states 0,1,2,5,0, with MemWrite=1 and AdrSrc=1 in state 5 only.
  - beq (`op`=1100011). Required: states 0,1,9,0, with ALUOp=01 and Branch=1 in state 9.
- jal and I-type:
  - jal (`op`=1101111). Required: states 0,1,10,8,0, with PCUpdate=1 in state 10.
  - I-type (`op`=0010011). Required: states 0,1,7,8,0, with ALUSrcB=01 and ALUOp=10 in state 7.
- Unsupported opcode:
  - Stimulus: `op`=0110111.
  - Required: states 0,1,0. RegWrite and MemWrite never assert.
- Mid-instruction reset:
  - Stimulus: `op`=0000011; assert `reset` while in MemRead (3).
  - Required: next state 0. RegWrite stays 0 throughout, and MemWB (4) never occurs.
